// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified memory arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} arb_state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

    localparam int unsigned MEM_LAT_DEF   = 2;
    localparam int unsigned MAX_BURST_DEF = 4;
    localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// IF/MEM request buses plus the single-port RAM bus seen by the arbiter.
interface unified_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          stall;

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        output if_ack, if_rdata, mem_ack, mem_rdata, ram_en, ram_we, ram_addr, ram_wdata, stall
    );

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata, ram_en, ram_we, ram_addr, ram_wdata, stall
    );
endinterface

// File: rtl/arb_lat_counter.sv
// Loadable down-counter that parks at zero; zero_o marks the last access cycle.
module arb_lat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one single-port RAM with
// a fixed access latency and a burst limit that keeps IF from starving.
module unified_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MEM_LAT   = MEM_LAT_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    unified_mem_arbiter_if.slave bus
);
    arb_state_e       state_q;
    owner_e           owner_q;
    logic [CNT_W-1:0] burst_q;
    logic             ram_en_q, ram_we_q, if_ack_q, mem_ack_q;
    logic [AW-1:0]    ram_addr_q;
    logic [DW-1:0]    ram_wdata_q, if_rdata_q, mem_rdata_q;

    logic mem_req, burst_full, mem_win, if_win, grant, cnt_zero;

    assign mem_req    = bus.mem_rd | bus.mem_wr;
    assign burst_full = (burst_q == CNT_W'(MAX_BURST));
    // MEM has priority until IF has watched MAX_BURST MEM grants go by.
    assign mem_win    = mem_req & ~(bus.if_req & burst_full);
    assign if_win     = ~mem_win & bus.if_req;
    assign grant      = (state_q == ST_IDLE) & (mem_win | if_win);

    arb_lat_counter #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (grant),
        .load_val_i (CNT_W'(MEM_LAT - 1)),
        .dec_i      (state_q == ST_BUSY),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            burst_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!bus.if_req || if_win) begin
                        burst_q <= '0;
                    end else if (mem_win && !burst_full) begin
                        burst_q <= burst_q + CNT_W'(1);
                    end
                    if (grant) begin
                        owner_q    <= mem_win ? OWN_MEM : OWN_IF;
                        ram_addr_q <= mem_win ? bus.mem_addr : bus.if_addr;
                        if (mem_win) ram_wdata_q <= bus.mem_wdata;
                        ram_en_q   <= 1'b1;
                        // A simultaneous rd+wr is served as a store.
                        ram_we_q   <= mem_win & bus.mem_wr;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_zero) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= bus.ram_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            if (!ram_we_q) mem_rdata_q <= bus.ram_rdata;
                            mem_ack_q <= 1'b1;
                        end
                        ram_en_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.stall     = (bus.if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, table-driven bench for unified_mem_arbiter with a small RAM model.
module tb_unified_mem_arbiter;
    localparam int unsigned MEM_LAT = 2;

    typedef struct {
        string       name;
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        exp_if_ack;
        logic        exp_mem_ack;
        int          exp_we_cyc;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_mem_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [31:0] ram [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    vec_t vecs [7];

    unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    unified_mem_arbiter #(
        .AW        (32),
        .DW        (32),
        .MEM_LAT   (MEM_LAT),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (bus.ram_en && bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = ram[bus.ram_addr[7:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drop_all();
        bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int lat, en_cyc, we_cyc;
        bit got;
        logic [31:0] exp_addr;
        @(negedge clk);
        bus.if_req = v.if_req;  bus.if_addr = v.if_addr;
        bus.mem_rd = v.mem_rd;  bus.mem_wr = v.mem_wr;
        bus.mem_addr = v.mem_addr; bus.mem_wdata = v.mem_wdata;
        exp_addr = (v.mem_rd || v.mem_wr) ? v.mem_addr : v.if_addr;
        lat = 0; en_cyc = 0; we_cyc = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.ram_en) en_cyc++;
            if (bus.ram_we) we_cyc++;
            if (lat == 1) begin
                chk({v.name, " ram_addr"}, bus.ram_addr, exp_addr);
                chk({v.name, " stall busy"}, 32'(bus.stall), 32'd1);
                if (v.mem_wr) chk({v.name, " ram_wdata"}, bus.ram_wdata, v.mem_wdata);
            end
            if (bus.if_ack || bus.mem_ack) got = 1'b1;
        end
        chk({v.name, " latency"}, lat, MEM_LAT + 1);
        chk({v.name, " if_ack"}, 32'(bus.if_ack), 32'(v.exp_if_ack));
        chk({v.name, " mem_ack"}, 32'(bus.mem_ack), 32'(v.exp_mem_ack));
        chk({v.name, " ram_en cycles"}, en_cyc, MEM_LAT);
        chk({v.name, " ram_we cycles"}, we_cyc, v.exp_we_cyc);
        chk({v.name, " if_rdata"}, bus.if_rdata, v.exp_if_rdata);
        chk({v.name, " mem_rdata"}, bus.mem_rdata, v.exp_mem_rdata);
        chk({v.name, " stall at ack"}, 32'(bus.stall), 32'd0);
        drop_all();
        @(negedge clk);
        chk({v.name, " ack cleared"}, 32'(bus.if_ack | bus.mem_ack), 32'd0);
        chk({v.name, " stall idle"}, 32'(bus.stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{"if_fetch_10",  1, 32'h10, 0, 0, 32'h0, 32'h0,    1, 0, 0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{"store_1",      0, 32'h0,  0, 1, 32'h1, 32'h1111, 0, 1, 2, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{"load_1",       0, 32'h0,  1, 0, 32'h1, 32'h0,    0, 1, 0, 32'hDEADBEEF, 32'h1111};
        vecs[3] = '{"if_fetch_20",  1, 32'h20, 0, 0, 32'h0, 32'h0,    1, 0, 0, 32'hCAFEF00D, 32'h1111};
        vecs[4] = '{"rd_wr_2",      0, 32'h0,  1, 1, 32'h2, 32'h2222, 0, 1, 2, 32'hCAFEF00D, 32'h1111};
        vecs[5] = '{"load_2",       0, 32'h0,  1, 0, 32'h2, 32'h0,    0, 1, 0, 32'hCAFEF00D, 32'h2222};
        vecs[6] = '{"if_refetch",   1, 32'h10, 0, 0, 32'h0, 32'h0,    1, 0, 0, 32'hDEADBEEF, 32'h2222};

        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.mem_rd = 1'b1; bus.mem_wr = 1'b0;
        bus.mem_addr = 32'h1; bus.mem_wdata = 32'h0;
        #1 rst_n = 1'b0;
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h20, 32'hCAFEF00D);
        preload(8'h03, 32'h00000033);
        @(negedge clk);
        chk("reset ram_en", 32'(bus.ram_en), 32'd0);
        chk("reset ram_we", 32'(bus.ram_we), 32'd0);
        chk("reset acks", 32'(bus.if_ack | bus.mem_ack), 32'd0);
        chk("reset if_rdata", bus.if_rdata, 32'h0);
        chk("reset mem_rdata", bus.mem_rdata, 32'h0);
        chk("reset ram_addr", bus.ram_addr, 32'h0);
        chk("reset stall", 32'(bus.stall), 32'd1);
        drop_all();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Contention: both held high, grants must go MEM x4 then IF.
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h1;
        for (int g = 0; g < 6; g++) begin
            int  w;
            bit  got;
            w = 0; got = 1'b0;
            while (!got && w < 20) begin
                @(negedge clk);
                w++;
                if (bus.if_ack || bus.mem_ack) got = 1'b1;
            end
            chk($sformatf("contention grant %0d seen", g), 32'(got), 32'd1);
            chk($sformatf("contention grant %0d is MEM", g), 32'(bus.mem_ack),
                (g == 4) ? 32'd0 : 32'd1);
            chk($sformatf("contention grant %0d is IF", g), 32'(bus.if_ack),
                (g == 4) ? 32'd1 : 32'd0);
            if (g == 4) chk("contention if_rdata", bus.if_rdata, 32'hDEADBEEF);
        end
        chk("contention mem_rdata", bus.mem_rdata, 32'h1111);
        drop_all();
        @(negedge clk);

        // Reset mid-BUSY aborts the store before the RAM ever samples ram_we.
        @(negedge clk);
        bus.mem_wr = 1'b1; bus.mem_addr = 32'h3; bus.mem_wdata = 32'h3333;
        @(negedge clk);
        chk("abort ram_we before reset", 32'(bus.ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort ram_en", 32'(bus.ram_en), 32'd0);
        chk("abort ram_we", 32'(bus.ram_we), 32'd0);
        chk("abort acks", 32'(bus.if_ack | bus.mem_ack), 32'd0);
        drop_all();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int acks;
            acks = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus.if_ack || bus.mem_ack) acks++;
            end
            chk("abort no late ack", acks, 0);
        end
        v = '{"post_reset_fetch", 1, 32'h20, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'hCAFEF00D, 32'h0};
        run_txn(v);
        v = '{"aborted_store_load", 0, 32'h0, 1, 0, 32'h3, 32'h0, 0, 1, 0, 32'hCAFEF00D, 32'h33};
        run_txn(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
